serial_addsub: RTL

Parametrised bit-serial adder/subtractor with a start/done handshake and per-bit valid qualification. Operands arrive LSB-first, one bit pair per accepted cycle, over WIDTH accepted bits. Each result bit is registered with its own valid strobe, and carry-out and two's-complement overflow are reported at completion. It is the general-width successor of the 4-bit serial adder in the shift-and-add datapath. It adds subtract mode, input stalls and abort.

---
 rtl/serial_addsub.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// serial_addsub
// Bit-serial adder/subtractor, operands presented LSB first.
//
// A start request (st) in IDLE latches the mode (sub) and the carry-in, then
// the block consumes WIDTH qualified bit pairs (vld=1) in RUN. Each accepted
// pair produces one registered result bit one cycle later. At the last bit,
// done pulses and cout/ovf report the final carry and the signed overflow.
// clr aborts a running operation without producing a done.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   st       start request (IDLE only)
//   sub      mode sampled with st: 0 = A+B, 1 = A-B
//   clr      synchronous abort of a running operation
//   vld      a/b carry a valid bit pair this cycle
//   a, b     serial operand bits, LSB first
//   busy     high while an operation is in RUN
//   sum      registered result bit (holds when sum_vld=0)
//   sum_vld  sum carries a fresh result bit this cycle
//   done     one-cycle pulse coincident with the MSB result bit
//   cout     final carry-out (subtract: 1 = no borrow)
//   ovf      two's-complement overflow of the completed operation

module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic st,
  input  logic sub,
  input  logic clr,
  input  logic vld,
  input  logic a,
  input  logic b,
  output logic busy,
  output logic sum,
  output logic sum_vld,
  output logic done,
  output logic cout,
  output logic ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic             mode_reg, mode_next;
  logic             carry_reg, carry_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sum_reg, sum_next;
  logic             sum_vld_reg, sum_vld_next;
  logic             done_reg, done_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;

  // Full-adder slice; subtraction inverts b and relies on the carry-in of 1
  // loaded at start.
  logic b_eff;
  logic bit_sum;
  logic bit_carry;

  assign b_eff     = b ^ mode_reg;
  assign bit_sum   = a ^ b_eff ^ carry_reg;
  assign bit_carry = (a & b_eff) | (a & carry_reg) | (b_eff & carry_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      mode_reg    <= 1'b0;
      carry_reg   <= 1'b0;
      cnt_reg     <= '0;
      sum_reg     <= 1'b0;
      sum_vld_reg <= 1'b0;
      done_reg    <= 1'b0;
      cout_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      mode_reg    <= mode_next;
      carry_reg   <= carry_next;
      cnt_reg     <= cnt_next;
      sum_reg     <= sum_next;
      sum_vld_reg <= sum_vld_next;
      done_reg    <= done_next;
      cout_reg    <= cout_next;
      ovf_reg     <= ovf_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mode_next    = mode_reg;
    carry_next   = carry_reg;
    cnt_next     = cnt_reg;
    sum_next     = sum_reg;
    sum_vld_next = 1'b0;
    done_next    = 1'b0;
    cout_next    = cout_reg;
    ovf_next     = ovf_reg;

    case (state_reg)
      IDLE: begin
        // clr is meaningless here and must not block a start.
        if (st) begin
          state_next = RUN;
          mode_next  = sub;
          carry_next = sub;
          cnt_next   = '0;
          cout_next  = 1'b0;
          ovf_next   = 1'b0;
        end
      end

      RUN: begin
        if (clr) begin
          state_next = IDLE;
        end else if (vld) begin
          sum_next     = bit_sum;
          sum_vld_next = 1'b1;
          carry_next   = bit_carry;
          if (cnt_reg == CNT_LAST) begin
            // cnt stays at the last index; it is reloaded on the next start.
            state_next = IDLE;
            done_next  = 1'b1;
            cout_next  = bit_carry;
            // Overflow: carry into the MSB differs from carry out of it.
            ovf_next   = carry_reg ^ bit_carry;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state_reg == RUN);
  assign sum     = sum_reg;
  assign sum_vld = sum_vld_reg;
  assign done    = done_reg;
  assign cout    = cout_reg;
  assign ovf     = ovf_reg;

endmodule
